// File: rtl/pcm_pkg.sv
// Shared widths and FSM state type for the transmit-side PCM compressor/serialiser.
package pcm_pkg;

    localparam int PCM_LIN_W   = 13;
    localparam int PCM_CODE_W  = 8;
    localparam int PCM_SEG_W   = 3;
    localparam int PCM_QUANT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pcm_state_e;

endpackage

// File: rtl/t_pcm_if.sv
// Sample handshake between the linear sample source and the PCM transmitter.
interface t_pcm_if;
    import pcm_pkg::*;

    logic [PCM_LIN_W-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/pcm_compress.sv
// Combinational 13-bit sign-magnitude to 8-bit segmented code compressor.
// Exact inverse of the 8->13 expander: truncates below quant, no even-bit inversion.
module pcm_compress
    import pcm_pkg::*;
(
    input  logic [PCM_LIN_W-1:0]  lin,
    output logic [PCM_CODE_W-1:0] code
);

    logic [PCM_LIN_W-2:0]   mag;
    logic [PCM_SEG_W-1:0]   seg;
    logic [PCM_QUANT_W-1:0] quant;

    assign mag = lin[PCM_LIN_W-2:0];

    // Ascending scan: the highest set bit in 11..5 wins and sets the segment.
    always_comb begin
        seg   = '0;
        quant = mag[4:1];
        for (int p = 5; p < PCM_LIN_W - 1; p++) begin
            if (mag[p]) begin
                seg   = PCM_SEG_W'(p - 4);
                quant = PCM_QUANT_W'(mag >> (p - 4));
            end
        end
    end

    assign code = {lin[PCM_LIN_W-1], seg, quant};

endmodule

// File: rtl/t_pcm.sv
// PCM transmitter: one-entry sample buffer, compressor, and MSB-first serialiser
// with frame sync on bit 7. Frames run back to back whenever the buffer is refilled in time.
module t_pcm
    import pcm_pkg::*;
#(
    parameter int CLK_DIV = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    t_pcm_if.slave                s,
    output logic [PCM_CODE_W-1:0] code_out,
    output logic                  pcm_sdo,
    output logic                  pcm_fs,
    output logic                  busy
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    pcm_state_e            state, state_nxt;
    logic [DIV_W-1:0]      div_cnt, div_nxt;
    logic [2:0]            bit_cnt, bit_nxt;
    logic [PCM_CODE_W-1:0] shreg, shreg_nxt;
    logic [PCM_CODE_W-1:0] code_nxt;
    logic                  sdo_nxt, fs_nxt, busy_nxt;
    logic                  buf_full;
    logic [PCM_CODE_W-1:0] buf_code;
    logic [PCM_CODE_W-1:0] enc_code;
    logic                  accept;
    logic                  load;

    pcm_compress u_compress (
        .lin  (s.s_data),
        .code (enc_code)
    );

    // s_ready comes straight from the buffer flag, so a load and an accept never share an edge.
    assign s.s_ready = !buf_full;
    assign accept    = s.s_valid && !buf_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
        end else if (load) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_code <= enc_code;
        end
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        code_nxt  = code_out;
        sdo_nxt   = pcm_sdo;
        fs_nxt    = pcm_fs;
        busy_nxt  = busy;
        load      = 1'b0;

        case (state)
            IDLE: begin
                if (buf_full) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    if (bit_cnt == 3'd0) begin
                        if (buf_full) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            div_nxt   = '0;
                            sdo_nxt   = 1'b0;
                            fs_nxt    = 1'b0;
                            busy_nxt  = 1'b0;
                        end
                    end else begin
                        div_nxt = '0;
                        bit_nxt = bit_cnt - 3'd1;
                        sdo_nxt = shreg[bit_cnt - 3'd1];
                        fs_nxt  = 1'b0;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A load from either state starts a fresh frame with bit 7 already on the line.
        if (load) begin
            state_nxt = SHIFT;
            div_nxt   = '0;
            bit_nxt   = 3'd7;
            shreg_nxt = buf_code;
            code_nxt  = buf_code;
            sdo_nxt   = buf_code[PCM_CODE_W-1];
            fs_nxt    = 1'b1;
            busy_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            code_out <= '0;
            pcm_sdo  <= 1'b0;
            pcm_fs   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            bit_cnt  <= bit_nxt;
            code_out <= code_nxt;
            pcm_sdo  <= sdo_nxt;
            pcm_fs   <= fs_nxt;
            busy     <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

endmodule
